instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage. Sits between the program-counter register and the IF/ID boundary.
//  Reads pc_q from the PC register and drives pc_d back to it. The PC register loads every clk,
//  so this block must drive pc_d = pc_q whenever the PC has to hold.
//  Issues one instruction-memory read at a time over a valid/ready request channel and accepts a
//  variable-latency response. Presents the fetched word to decode through an IF/ID register with
//  stall support, backed by a 1-entry skid buffer. A redirect squashes all fetch state.
// PARAMETERS
//  XLEN     64  PC / address width
//  ILEN     32  instruction width
//  PC_STEP  4   sequential PC increment (bytes)
// PORTS
//  clk             in   1     clock, rising edge
//  reset           in   1     asynchronous, active-high
//  pc_q            in   XLEN  current PC from the PC register
//  pc_d            out  XLEN  next PC to the PC register
//  redirect_valid  in   1     branch/jump/trap redirect, single-cycle pulse
//  redirect_pc     in   XLEN  redirect target
//  imem_req_valid  out  1     read request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  request address (= pc_q)
//  imem_rsp_valid  in   1     read data valid
//  imem_rsp_data   in   ILEN  read data
//  id_stall        in   1     decode cannot accept; hold IF/ID
//  ifid_valid      out  1     IF/ID holds a valid instruction
//  ifid_pc         out  XLEN  PC of the IF/ID instruction
//  ifid_instr      out  ILEN  IF/ID instruction word
// BEHAVIOUR
//  - Reset values: state=S_REQ, ifid_valid=0, ifid_pc=0, ifid_instr=0, skid empty, req_pc=0.
//  - While reset is asserted: imem_req_valid=0 and pc_d=pc_q.
//  - State S_REQ:
//    - imem_req_valid = !skid_full && !redirect_valid; imem_req_addr = pc_q.
//    - On handshake (valid & ready): req_pc <= pc_q; pc_d = pc_q + PC_STEP (mod 2^XLEN); next state S_WAIT.
//    - Otherwise pc_d = pc_q.
//  - State S_WAIT: imem_req_valid=0, pc_d=pc_q. When imem_rsp_valid: go to S_REQ and route the data:
//    - if !ifid_valid or !id_stall: IF/ID <= {1, req_pc, rsp_data};
//    - else: skid <= {req_pc, rsp_data} and skid_full <= 1.
//  - State S_DROP: waits for the response of a squashed request.
//    - imem_req_valid=0, pc_d=pc_q.
//    - On imem_rsp_valid: discard the data, go to S_REQ.
//  - imem_rsp_valid is ignored in S_REQ.
//  - IF/ID drain: when id_stall=0 and no response is loading, IF/ID <= skid if skid_full (then clear
//    skid_full), else ifid_valid <= 0. Response latency to IF/ID: 1 clk after imem_rsp_valid.
//  - Redirect: highest priority, overrides everything above in the same cycle.
//    - pc_d = {redirect_pc[XLEN-1:2], 2'b00}; ifid_valid <= 0; skid_full <= 0.
//    - S_REQ: no request issued (imem_req_valid forced 0); stay in S_REQ.
//    - S_WAIT without rsp_valid: go to S_DROP.
//    - S_WAIT with rsp_valid in the same cycle: drop the response, go to S_REQ.
//    - S_DROP: stay in S_DROP, or go to S_REQ if rsp_valid.
//  - Only one request is outstanding at any time. No request is issued while skid_full=1.
//  - pc_d wraps: 0xFFFF_FFFF_FFFF_FFFC + 4 -> 0x0.
//  - Reset mid-fetch: any in-flight response is lost. Memory is reset by the same signal.
// TESTING
//  - Reset released, pc_q=0, ready=1, rsp 2 clk later = 0x00000013
//    -> req addr 0x0; pc_d=0x4 on the handshake cycle; ifid_valid=1, ifid_pc=0x0, ifid_instr=0x00000013.
//  - Back-to-back fetches, zero-wait memory -> ifid_pc sequence 0x0, 0x4, 0x8; no gaps other than
//    the 1-cycle request/response turnaround.
//  - id_stall=1 with IF/ID full, rsp 0xDEADBEEF arrives -> word goes to the skid buffer;
//    imem_req_valid=0; release stall -> ifid_instr=0xDEADBEEF next clk.
//  - redirect_valid with redirect_pc=0x1002 while in S_WAIT -> pc_d=0x1000; ifid_valid=0;
//    next rsp dropped; next request addr=0x1000.
//  - redirect coincident with rsp_valid -> response discarded, state S_REQ, ifid_valid=0.
//  - pc_q=0xFFFF_FFFF_FFFF_FFFC fetch -> pc_d=0x0; reset asserted in S_WAIT -> ifid_valid=0 and
//    imem_req_valid=0 immediately (async).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with IF/ID register, 1-entry skid buffer and redirect squash
module instr_fetch_unit #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            id_stall,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [ILEN-1:0] ifid_instr
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            skid_full_q, skid_full_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [ILEN-1:0] skid_instr_q, skid_instr_d;
  logic            in_wait, in_drop, hs, rsp_load, to_ifid, to_skid;
  assign in_wait        = state_q == S_WAIT;
  assign in_drop        = state_q == S_DROP;
  assign imem_req_valid = !reset && state_q == S_REQ && !skid_full_q && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign pc_d           = reset ? pc_q : redirect_valid ? (redirect_pc & ALIGN_MASK) :
                          hs ? pc_q + XLEN'(PC_STEP) : pc_q;
  // A redirect in the response cycle discards the word instead of loading it
  assign rsp_load       = in_wait && imem_rsp_valid && !redirect_valid;
  assign to_ifid        = rsp_load && (!ifid_valid_q || !id_stall);
  assign to_skid        = rsp_load && ifid_valid_q && id_stall;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_pc        = ifid_pc_q;
  assign ifid_instr     = ifid_instr_q;
  always_comb begin
    state_d      = hs ? S_WAIT : (in_wait || in_drop) ?
                   (imem_rsp_valid ? S_REQ : (in_wait && redirect_valid) ? S_DROP : state_q) : S_REQ;
    req_pc_d     = hs ? pc_q : req_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    skid_full_d  = skid_full_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (to_ifid) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = req_pc_q;
      ifid_instr_d = imem_rsp_data;
    end else if (to_skid) begin
      skid_full_d  = 1'b1;
      skid_pc_d    = req_pc_q;
      skid_instr_d = imem_rsp_data;
    end else if (!id_stall) begin
      ifid_valid_d = skid_full_q;
      ifid_pc_d    = skid_full_q ? skid_pc_q : ifid_pc_q;
      ifid_instr_d = skid_full_q ? skid_instr_q : ifid_instr_q;
      skid_full_d  = 1'b0;
    end
    if (redirect_valid) begin
      ifid_valid_d = 1'b0;
      skid_full_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      req_pc_q     <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      skid_full_q  <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      skid_full_q  <= skid_full_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, skid, redirect, wrap and async reset
module tb_instr_fetch_unit;
  logic        clk = 0, reset = 1;
  logic [63:0] pc_q, pc_d, pc_init = 64'h0, redirect_pc = 64'h0, imem_req_addr, ifid_pc;
  logic        redirect_valid = 0, imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 32'h0, ifid_instr;
  logic        id_stall = 0, ifid_valid;
  int          errors = 0, checks = 0;
  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_q(pc_q), .pc_d(pc_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .id_stall(id_stall),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge reset) pc_q <= reset ? pc_init : pc_d;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    tick();
    imem_req_ready = 1;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_pc_d", pc_d, 64'h0);
    chk("rst_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("rst_ifid_pc", ifid_pc, 64'h0);
    chk("rst_ifid_instr", 64'(ifid_instr), 64'h0);
    tick();
    reset = 0;
    #1;
    chk("f0_req_valid", 64'(imem_req_valid), 64'h1);
    chk("f0_req_addr", imem_req_addr, 64'h0);
    chk("f0_pc_d", pc_d, 64'h4);
    tick();
    chk("f0_wait_req_valid", 64'(imem_req_valid), 64'h0);
    chk("f0_wait_pc_d", pc_d, 64'h4);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 0;
    chk("f0_ifid_valid", 64'(ifid_valid), 64'h1);
    chk("f0_ifid_pc", ifid_pc, 64'h0);
    chk("f0_ifid_instr", 64'(ifid_instr), 64'h13);
    chk("f1_req_addr", imem_req_addr, 64'h4);
    tick();
    chk("f1_drain_valid", 64'(ifid_valid), 64'h0);
    imem_rsp_valid = 1; imem_rsp_data = 32'h11;
    tick();
    imem_rsp_valid = 0;
    chk("f1_ifid_pc", ifid_pc, 64'h4);
    chk("f1_ifid_instr", 64'(ifid_instr), 64'h11);
    chk("f2_req_addr", imem_req_addr, 64'h8);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h22;
    tick();
    imem_rsp_valid = 0;
    chk("f2_ifid_pc", ifid_pc, 64'h8);
    chk("f2_ifid_instr", 64'(ifid_instr), 64'h22);
    id_stall = 1;
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 0;
    #1;
    chk("skid_ifid_held", 64'(ifid_instr), 64'h22);
    chk("skid_ifid_valid", 64'(ifid_valid), 64'h1);
    chk("skid_req_blocked", 64'(imem_req_valid), 64'h0);
    chk("skid_pc_hold", pc_d, 64'h10);
    tick();
    chk("skid_req_blocked2", 64'(imem_req_valid), 64'h0);
    id_stall = 0;
    tick();
    chk("skid_drain_instr", 64'(ifid_instr), 64'hDEAD_BEEF);
    chk("skid_drain_pc", ifid_pc, 64'hC);
    chk("skid_drain_req", 64'(imem_req_valid), 64'h1);
    id_stall = 1;
    tick();
    chk("rd_pre_valid", 64'(ifid_valid), 64'h1);
    redirect_valid = 1; redirect_pc = 64'h1002;
    #1;
    chk("rd_pc_d", pc_d, 64'h1000);
    tick();
    redirect_valid = 0; id_stall = 0;
    #1;
    chk("rd_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("rd_drop_req", 64'(imem_req_valid), 64'h0);
    chk("rd_drop_pc_d", pc_d, 64'h1000);
    imem_rsp_valid = 1; imem_rsp_data = 32'h0BAD;
    tick();
    imem_rsp_valid = 0;
    #1;
    chk("rd_dropped_valid", 64'(ifid_valid), 64'h0);
    chk("rd_next_req", 64'(imem_req_valid), 64'h1);
    chk("rd_next_addr", imem_req_addr, 64'h1000);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h55;
    redirect_valid = 1; redirect_pc = 64'h2000;
    #1;
    chk("rc_pc_d", pc_d, 64'h2000);
    tick();
    imem_rsp_valid = 0; redirect_valid = 0;
    #1;
    chk("rc_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("rc_state_req", 64'(imem_req_valid), 64'h1);
    chk("rc_addr", imem_req_addr, 64'h2000);
    redirect_valid = 1; redirect_pc = 64'h3001;
    #1;
    chk("rq_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rq_pc_d", pc_d, 64'h3000);
    tick();
    redirect_valid = 0;
    #1;
    chk("rq_req_after", 64'(imem_req_valid), 64'h1);
    chk("rq_addr_after", imem_req_addr, 64'h3000);
    pc_init = 64'hFFFF_FFFF_FFFF_FFFC;
    reset = 1;
    #1;
    chk("wr_rst_pc_d", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    reset = 0;
    #1;
    chk("wr_req_valid", 64'(imem_req_valid), 64'h1);
    chk("wr_pc_d", pc_d, 64'h0);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h77;
    tick();
    imem_rsp_valid = 0;
    chk("wr_ifid_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_ifid_instr", 64'(ifid_instr), 64'h77);
    id_stall = 1;
    tick();
    chk("ar_pre_valid", 64'(ifid_valid), 64'h1);
    chk("ar_pre_wait", 64'(imem_req_valid), 64'h0);
    #2;
    reset = 1;
    #1;
    chk("ar_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("ar_req_valid", 64'(imem_req_valid), 64'h0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
